div_sequencer: RTL and testbench

//  Control FSM for the bit-serial signed/unsigned divider. Drives the load,

---
 rtl/div_sequencer_if.sv | 39 +++
 rtl/div_sequencer.sv | 134 +++++++++++++
 tb/tb_div_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Handshake and strobe bundle between the divider sequencer and its host/datapath.
// The sequencer uses the master view. The host and bitslice datapath use the slave view.
interface div_sequencer_if;
  logic Start;
  logic Signed;
  logic Op1Sign;
  logic Op2Sign;
  logic DivZero;
  logic SubNeg;
  logic LOAD_DIVH;
  logic LOAD_DIVL;
  logic LOAD_ACC;
  logic SHIFT;
  logic STORE_ACC;
  logic STORE_QUOT;
  logic STORE_REM;
  logic INV_OP1;
  logic INV_OP2;
  logic INV_RESULT;
  logic INV_REM;
  logic QuotBit;
  logic Busy;
  logic Done;
  logic Error;

  modport master (
    input  Start, Signed, Op1Sign, Op2Sign, DivZero, SubNeg,
    output LOAD_DIVH, LOAD_DIVL, LOAD_ACC, SHIFT, STORE_ACC, STORE_QUOT,
           STORE_REM, INV_OP1, INV_OP2, INV_RESULT, INV_REM, QuotBit,
           Busy, Done, Error
  );

  modport slave (
    output Start, Signed, Op1Sign, Op2Sign, DivZero, SubNeg,
    input  LOAD_DIVH, LOAD_DIVL, LOAD_ACC, SHIFT, STORE_ACC, STORE_QUOT,
           STORE_REM, INV_OP1, INV_OP2, INV_RESULT, INV_REM, QuotBit,
           Busy, Done, Error
  );
endinterface

// File: rtl/div_sequencer.sv
// Control FSM for the bit-serial restoring divider. It runs one SHIFT/TRIAL pair
// per quotient bit and applies sign fix-up on load and on store.
module div_sequencer #(
  parameter int WIDTH = 8
) (
  input logic            Clock,
  input logic            Reset,
  div_sequencer_if.master bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRIAL = 3'd3,
    S_FIXUP = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nd_q, nd_d;
  logic          nv_q, nv_d;
  logic          nq_q, nq_d;
  logic          error_q, error_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nd_q    <= 1'b0;
      nv_q    <= 1'b0;
      nq_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nd_q    <= nd_d;
      nv_q    <= nv_d;
      nq_q    <= nq_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    nd_d           = nd_q;
    nv_d           = nv_q;
    nq_d           = nq_q;
    error_d        = error_q;
    bus.LOAD_DIVH  = 1'b0;
    bus.LOAD_DIVL  = 1'b0;
    bus.LOAD_ACC   = 1'b0;
    bus.SHIFT      = 1'b0;
    bus.STORE_ACC  = 1'b0;
    bus.STORE_QUOT = 1'b0;
    bus.STORE_REM  = 1'b0;
    bus.INV_OP1    = 1'b0;
    bus.INV_OP2    = 1'b0;
    bus.INV_RESULT = 1'b0;
    bus.INV_REM    = 1'b0;
    bus.QuotBit    = 1'b0;
    bus.Busy       = 1'b0;
    bus.Done       = 1'b0;
    bus.Error      = 1'b0;

    case (state_q)
      S_IDLE: begin
        error_d = 1'b0;
        if (bus.Start) begin
          state_d = S_LOAD;
          nd_d    = bus.Signed & bus.Op1Sign;
          nv_d    = bus.Signed & bus.Op2Sign;
          nq_d    = (bus.Signed & bus.Op1Sign) ^ (bus.Signed & bus.Op2Sign);
        end
      end
      S_LOAD: begin
        bus.LOAD_DIVH = 1'b1;
        bus.LOAD_DIVL = 1'b1;
        bus.LOAD_ACC  = 1'b1;
        bus.INV_OP1   = nd_q;
        bus.INV_OP2   = nv_q;
        bus.Busy      = 1'b1;
        cnt_d         = '0;
        if (bus.DivZero) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          state_d = S_SHIFT;
          error_d = 1'b0;
        end
      end
      S_SHIFT: begin
        bus.SHIFT = 1'b1;
        bus.Busy  = 1'b1;
        state_d   = S_TRIAL;
      end
      S_TRIAL: begin
        // A non-negative trial difference sets the quotient bit and is committed to DIVH.
        bus.QuotBit   = ~bus.SubNeg;
        bus.STORE_ACC = ~bus.SubNeg;
        bus.Busy      = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_SHIFT;
        end
      end
      S_FIXUP: begin
        bus.STORE_QUOT = 1'b1;
        bus.STORE_REM  = 1'b1;
        bus.INV_RESULT = nq_q;
        bus.INV_REM    = nd_q;
        bus.Busy       = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        bus.Done  = 1'b1;
        bus.Error = error_q;
        error_d   = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer (WIDTH=8). It checks every output on every cycle
// against expected vectors that were worked out by hand from the cycle timeline.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic srst;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_sequencer_if bus ();

  div_sequencer #(.WIDTH(8)) dut (
    .Clock (clk),
    .Reset (srst),
    .bus   (bus)
  );

  typedef struct packed {
    logic load_divh, load_divl, load_acc, shift, store_acc, store_quot, store_rem;
    logic inv_op1, inv_op2, inv_result, inv_rem, quot_bit, busy, done, error;
  } outs_t;

  function automatic outs_t sample_outs();
    outs_t o;
    o.load_divh  = bus.LOAD_DIVH;
    o.load_divl  = bus.LOAD_DIVL;
    o.load_acc   = bus.LOAD_ACC;
    o.shift      = bus.SHIFT;
    o.store_acc  = bus.STORE_ACC;
    o.store_quot = bus.STORE_QUOT;
    o.store_rem  = bus.STORE_REM;
    o.inv_op1    = bus.INV_OP1;
    o.inv_op2    = bus.INV_OP2;
    o.inv_result = bus.INV_RESULT;
    o.inv_rem    = bus.INV_REM;
    o.quot_bit   = bus.QuotBit;
    o.busy       = bus.Busy;
    o.done       = bus.Done;
    o.error      = bus.Error;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete division, starting from IDLE. The Start edge is E0, so cycle 1 is LOAD.
  // subneg lists the SubNeg values for TRIALs 1..8, read from left to right.
  task automatic run_div(input string name, input logic sgn, input logic s1, input logic s2,
                         input logic dz, input logic [7:0] subneg);
    outs_t e;
    logic  nd, nv, sn;
    nd = sgn & s1;
    nv = sgn & s2;
    bus.Start   = 1'b1;
    bus.Signed  = sgn;
    bus.Op1Sign = s1;
    bus.Op2Sign = s2;
    bus.DivZero = dz;
    tick();
    // Changing these after the Start edge must have no effect.
    bus.Start   = 1'b0;
    bus.Signed  = ~sgn;
    bus.Op1Sign = ~s1;
    bus.Op2Sign = ~s2;
    #1;
    e = '0; e.load_divh = 1; e.load_divl = 1; e.load_acc = 1;
    e.inv_op1 = nd; e.inv_op2 = nv; e.busy = 1;
    check({name, " load"}, sample_outs(), e);
    if (dz) begin
      tick(); #1;
      e = '0; e.done = 1; e.error = 1;
      check({name, " dz_done"}, sample_outs(), e);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tick(); #1;
        e = '0; e.shift = 1; e.busy = 1;
        check($sformatf("%s shift%0d", name, i + 1), sample_outs(), e);
        tick();
        sn = subneg[7 - i];
        bus.SubNeg = sn;
        #1;
        e = '0; e.quot_bit = ~sn; e.store_acc = ~sn; e.busy = 1;
        check($sformatf("%s trial%0d", name, i + 1), sample_outs(), e);
      end
      tick(); #1;
      e = '0; e.store_quot = 1; e.store_rem = 1; e.inv_result = nd ^ nv; e.inv_rem = nd; e.busy = 1;
      check({name, " fixup"}, sample_outs(), e);
      tick(); #1;
      e = '0; e.done = 1;
      check({name, " done"}, sample_outs(), e);
    end
    tick(); #1;
    check({name, " idle"}, sample_outs(), 32'd0);
    bus.DivZero = 1'b0;
    bus.SubNeg  = 1'b0;
    bus.Signed  = 1'b0;
    bus.Op1Sign = 1'b0;
    bus.Op2Sign = 1'b0;
  endtask

  initial begin
    int n_load, n_done, load2_cyc, done2_cyc;
    srst        = 1'b1;
    bus.Start   = 1'b0;
    bus.Signed  = 1'b0;
    bus.Op1Sign = 1'b0;
    bus.Op2Sign = 1'b0;
    bus.DivZero = 1'b0;
    bus.SubNeg  = 1'b0;
    tick(); tick(); #1;
    check("reset outputs", sample_outs(), 32'd0);
    srst = 1'b0;
    tick(); #1;
    check("idle outputs", sample_outs(), 32'd0);

    // Reset held for two edges while the FSM is in the first TRIAL.
    bus.Start = 1'b1;
    tick(); bus.Start = 1'b0;   // LOAD
    tick();                     // SHIFT
    tick(); bus.SubNeg = 1'b0;  // TRIAL
    #1;
    check("pre-reset trial qbit", 32'(bus.QuotBit), 32'd1);
    srst = 1'b1;
    tick(); #1;
    check("in reset outputs", sample_outs(), 32'd0);
    tick();
    srst = 1'b0;
    #1;
    check("after reset outputs", sample_outs(), 32'd0);
    tick(); #1;
    check("after reset stays idle", sample_outs(), 32'd0);

    run_div("unsigned", 1'b0, 1'b0, 1'b0, 1'b0, 8'b10110010);
    run_div("neg_by_pos", 1'b1, 1'b1, 1'b0, 1'b0, 8'b01010101);
    run_div("neg_by_neg", 1'b1, 1'b1, 1'b1, 1'b0, 8'b11110000);
    run_div("pos_by_neg", 1'b1, 1'b0, 1'b1, 1'b0, 8'b00001111);
    run_div("unsigned_msbs", 1'b0, 1'b1, 1'b1, 1'b0, 8'b00000000);
    run_div("divzero", 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000);
    run_div("divzero_signed", 1'b1, 1'b1, 1'b0, 1'b1, 8'b00000000);

    // Start held high for 30 edges: expect exactly two divisions.
    n_load = 0; n_done = 0; load2_cyc = -1; done2_cyc = -1;
    bus.Start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c >= 30) bus.Start = 1'b0;
      #1;
      if (bus.LOAD_DIVH) begin n_load++; if (n_load == 2) load2_cyc = c; end
      if (bus.Done)      begin n_done++; if (n_done == 2) done2_cyc = c; end
    end
    check("held start loads", 32'(n_load), 32'd2);
    check("held start dones", 32'(n_done), 32'd2);
    check("second load cycle", 32'(load2_cyc), 32'd21);
    check("second done cycle", 32'(done2_cyc), 32'd39);
    check("held start end idle", sample_outs(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
